// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin Wishbone classic arbiter
//
// Purpose: shares one Wishbone slave between master 0 (core fetch/load-store)
// and master 1 (loader/debug). The grant is round-robin and is held for the
// whole cyc of the winning master. The slave side is a plain mux of the
// granted master, and the slave ack is steered back to the grant holder only.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   m0_* / m1_*           master ports (cyc/stb/we/sel/adr/dat in, dat/ack out)
//   s_*                   slave port (cyc/stb/we/sel/adr/dat out, dat/ack in)
//   grant_o               registered one-hot grant {m1,m0}, 00 when idle
//   timeout_o             sticky stall-timeout flag
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add the stall watchdog. After
// TIMEOUT_CYCLES un-acked strobe cycles it answers the holder with a synthetic
// ack carrying all-ones data, drops s_cyc_o/s_stb_o for that cycle and sets
// timeout_o. Without the macro timeout_o is tied low.

module wb_arbiter2 #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;     // master that released the bus most recently
    logic   tmo_hit;            // synthetic-ack cycle of the watchdog

    // A stall limit below 2 would fire before any real slave could answer.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_below_min
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;    // core wins the first tie after reset
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Release goes straight to the other master when it is waiting, so the
    // only gap between holders is the releasing master's own cyc-low cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_o = {state_q == GNT1, state_q == GNT0};

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             holder_stb;

    always_comb begin
        holder_stb = 1'b0;
        if (state_q == GNT0) begin
            holder_stb = m0_stb_i;
        end else if (state_q == GNT1) begin
            holder_stb = m1_stb_i;
        end
        tmo_hit   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
        timeout_d = timeout_q | tmo_hit;
        cnt_d     = cnt_q;
        // The synthetic ack finishes the transfer just like a real one.
        if ((state_d != state_q) || s_ack_i || tmo_hit) begin
            cnt_d = '0;
        end else if (holder_stb) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Slave mux and ack steering. Read data is broadcast; only the holder's
    // ack qualifies it, and s_ack_i is dropped entirely while idle.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i & ~tmo_hit;
                s_stb_o  = m0_stb_i & ~tmo_hit;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i | tmo_hit;
                if (tmo_hit) begin
                    m0_dat_o = '1;
                end
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i & ~tmo_hit;
                s_stb_o  = m1_stb_i & ~tmo_hit;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i | tmo_hit;
                if (tmo_hit) begin
                    m1_dat_o = '1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - self-checking bench for wb_arbiter2

module tb_wb_arbiter2;

    typedef struct {
        logic [1:0]  g;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    wire  [31:0] m_rdat [2];
    wire  [1:0]  m_ack;
    wire         s_cyc, s_stb, s_we;
    wire  [3:0]  s_sel;
    wire  [31:0] s_adr, s_dat_o;
    logic [31:0] slv_rdat;
    logic        slv_ack;
    logic        inj_ack = 1'b0;
    wire         s_ack = slv_ack | inj_ack;
    wire  [1:0]  grant;
    wire         timeout;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    slv_hang = 1'b0;
    bit    slv_rand = 1'b0;
    int    slv_lat = 0;
    int    slv_wait;
    int    slv_rlat;
    xfer_t slv_log [$];
    xfer_t exp_q0 [$];
    xfer_t exp_q1 [$];

    always #5 clk = ~clk;

    wb_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m_rdat[0]), .m0_ack_o(m_ack[0]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m_rdat[1]), .m1_ack_o(m_ack[1]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(slv_rdat), .s_ack_i(s_ack),
        .grant_o(grant), .timeout_o(timeout)
    );

    function automatic logic [31:0] rd_pattern(input logic [31:0] adr);
        return adr ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [79:0] pack(input xfer_t e);
        return {9'd0, e.g, e.we, e.adr, e.dat, e.sel};
    endfunction

    // Slave model: acks each strobe after a (possibly random) wait, then
    // drops ack for at least one cycle; every accepted transfer is logged.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            slv_ack  <= 1'b0;
            slv_wait <= 0;
            slv_rlat <= 0;
            slv_rdat <= '0;
        end else if (slv_ack) begin
            slv_ack <= 1'b0;
        end else if (s_cyc && s_stb && !slv_hang) begin
            if (slv_wait >= (slv_rand ? slv_rlat : slv_lat)) begin
                slv_ack  <= 1'b1;
                slv_wait <= 0;
                slv_rdat <= rd_pattern(s_adr);
                slv_rlat <= int'($urandom_range(0, 3));
                slv_log.push_back('{grant, s_we, s_adr, s_dat_o, s_sel});
            end else begin
                slv_wait <= slv_wait + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        xfer_t e;
        m_we[m] = we; m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel;
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
        e = '{(m == 0) ? 2'b01 : 2'b10, we, adr, dat, sel};
        if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    endtask

    task automatic finish_ack(input int m);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (m_ack[m]) got = 1'b1;
        end
        check($sformatf("ack_arrives_m%0d", m), got, 1);
        if (got) begin
            check($sformatf("grant_at_ack_m%0d", m), grant, (m == 0) ? 2'b01 : 2'b10);
            check($sformatf("other_ack_low_m%0d", m), m_ack[1-m], 0);
            if (!m_we[m]) check($sformatf("rdata_m%0d", m), m_rdat[m], rd_pattern(m_adr[m]));
        end
        @(posedge clk); #1;
        m_stb[m] = 1'b0;
    endtask

    task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
        issue(m, we, adr, dat, sel);
        finish_ack(m);
    endtask

    task automatic drain();
        xfer_t e, x;
        while (slv_log.size() > 0) begin
            e = slv_log.pop_front();
            if (e.g == 2'b01 && exp_q0.size() > 0) begin
                x = exp_q0.pop_front();
                check("slave_xfer_m0", pack(e), pack(x));
            end else if (e.g == 2'b10 && exp_q1.size() > 0) begin
                x = exp_q1.pop_front();
                check("slave_xfer_m1", pack(e), pack(x));
            end else begin
                check("unexpected_slave_xfer", pack(e), 80'd0);
            end
        end
        check("m0_all_delivered", exp_q0.size(), 0);
        check("m1_all_delivered", exp_q1.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
        end
        slv_hang = 1'b0; inj_ack = 1'b0;
        #1;
        check("reset_grant", grant, 2'b00);
        check("reset_s_cyc", s_cyc, 0);
        @(negedge clk);
        reset = 1'b1;
        exp_q0.delete(); exp_q1.delete(); slv_log.delete();
    endtask

    task automatic rand_master(input int m, input int bursts);
        for (int b = 0; b < bursts; b++) begin
            int n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) begin
                xfer(m, 1'($urandom), {$urandom} & 32'hFFFF_FFFC, $urandom,
                     4'($urandom_range(1, 15)));
            end
            m_cyc[m] = 1'b0;
            @(posedge clk); #1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit got;
        int stall;
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_sel[m] = '0; m_adr[m] = '0; m_dat[m] = '0;
        end
        #12;
        check("por_grant", grant, 2'b00);
        check("por_timeout", timeout, 0);
        do_reset();

        // Single core read: one-cycle arbitration latency, slave waits 2.
        slv_lat = 2;
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
        @(negedge clk);
        check("t1_grant_latency", grant, 2'b00);
        check("t1_s_cyc_latency", s_cyc, 0);
        @(negedge clk);
        check("t1_grant_m0", grant, 2'b01);
        check("t1_s_adr", s_adr, 32'h4000_0000);
        finish_ack(0);
        m_cyc[0] = 1'b0;
        drain();

        // Simultaneous requests after reset: core first, hand-over without idle.
        do_reset();
        slv_lat = 0;
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        issue(1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
        @(negedge clk);
        check("t2_grant_latency", grant, 2'b00);
        @(negedge clk);
        check("t2_first_grant", grant, 2'b01);
        check("t2_first_adr", s_adr, 32'h0000_1000);
        finish_ack(0);
        m_cyc[0] = 1'b0;
        @(negedge clk);
        check("t2_release_cycle_grant", grant, 2'b01);
        check("t2_release_cycle_s_cyc", s_cyc, 0);
        @(negedge clk);
        check("t2_handover_grant", grant, 2'b10);
        check("t2_handover_adr", s_adr, 32'h0000_2000);
        finish_ack(1);
        m_cyc[1] = 1'b0;
        drain();

        // Loader holds cyc for three writes while the core waits.
        slv_lat = 1;
        @(posedge clk); #1;
        fork
            begin
                xfer(1, 1'b1, 32'h8000_0000, $urandom, 4'hF);
                xfer(1, 1'b1, 32'h8000_0004, $urandom, 4'h3);
                xfer(1, 1'b1, 32'h8000_0008, $urandom, 4'hC);
                m_cyc[1] = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                xfer(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
                m_cyc[0] = 1'b0;
            end
        join
        check("t3_log_size", slv_log.size(), 4);
        if (slv_log.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("t3_order_%0d", i), slv_log[i].g, (i < 3) ? 2'b10 : 2'b01);
        end
        drain();

        // Back-to-back requests from both: strict alternation, core first.
        do_reset();
        slv_lat = 0;
        @(posedge clk); #1;
        fork
            for (int k = 0; k < 4; k++) begin
                xfer(0, 1'b1, 32'h0000_0400 + 32'(k * 4), $urandom, 4'hF);
                m_cyc[0] = 1'b0;
                @(posedge clk); #1;
            end
            for (int k = 0; k < 4; k++) begin
                xfer(1, 1'b0, 32'h0000_0800 + 32'(k * 4), $urandom, 4'hF);
                m_cyc[1] = 1'b0;
                @(posedge clk); #1;
            end
        join
        check("t4_log_size", slv_log.size(), 8);
        if (slv_log.size() == 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("t4_alternation_%0d", i), slv_log[i].g,
                      (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        drain();

        // Idle: strobe without cyc is not arbitrated, stray slave ack ignored.
        m_we[0] = 1'b1; m_sel[0] = 4'hF; m_adr[0] = 32'hDEAD_0000; m_dat[0] = 32'h1234_5678;
        m_stb[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inj_ack = 1'b1;
        #1;
        check("idle_grant", grant, 2'b00);
        check("idle_s_bus", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o}, 0);
        check("idle_acks", m_ack, 2'b00);
        @(posedge clk); #1;
        inj_ack = 1'b0;
        m_stb[0] = 1'b0;

        // Reset mid-transfer drops the bus at once; core wins afterwards.
        slv_hang = 1'b1;
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        @(negedge clk);
        @(negedge clk);
        check("t5_granted_before_reset", grant, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_s_cyc", s_cyc, 0);
        check("t5_async_grant", grant, 2'b00);
        exp_q0.delete(); exp_q1.delete(); slv_log.delete();
        issue(0, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        issue(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        @(negedge clk);
        reset = 1'b1;
        slv_hang = 1'b0;
        @(negedge clk);
        check("t5_fresh_grant", grant, 2'b01);
        finish_ack(0);
        m_cyc[0] = 1'b0;
        finish_ack(1);
        m_cyc[1] = 1'b0;
        drain();

        // Randomized traffic from both masters, random slave latency.
        slv_rand = 1'b1;
        @(posedge clk); #1;
        fork
            rand_master(0, 12);
            rand_master(1, 12);
        join
        drain();
        slv_rand = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
        do_reset();
        slv_hang = 1'b1;
        @(posedge clk); #1;
        issue(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
        got = 1'b0;
        stall = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (m_ack[0]) got = 1'b1;
            else if (grant == 2'b01) stall++;
        end
        check("tmo_ack", got, 1);
        check("tmo_stall_cycles", stall, 16);
        check("tmo_data", m_rdat[0], 32'hFFFF_FFFF);
        check("tmo_s_cyc_forced", s_cyc, 0);
        @(posedge clk); #1;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_sticky", timeout, 1);
        slv_hang = 1'b0;
        exp_q0.delete();
`else
        check("timeout_tied_low", timeout, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
